// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types, widths and saturation limits for the Booth dot-product datapath
// Contents: PROD_W (multiplier product width), state_t (ACC/DONE),
//           sat_max/sat_min (signed range limits for a given width).
package booth_pkg;

   localparam int PROD_W = 8;

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   // Largest positive value representable in a w-bit two's complement word.
   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Most negative value representable in a w-bit two's complement word.
   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/booth_acc_add.sv
// rtl/booth_acc_add.sv - combinational ACC_W signed adder of accumulator plus product, with overflow flag
// Ports: a   - current accumulator (ACC_W, signed)
//        b   - product from the multiplier (PROD_W, signed, sign-extended here)
//        sum - next accumulator value (wraps, or clamps when BOOTH_ACC_SAT_EN is defined)
//        ovf - the addition left the signed ACC_W range
// Build option: BOOTH_ACC_SAT_EN selects saturating instead of wrapping results.
module booth_acc_add
   import booth_pkg::*;
#(
   parameter int ACC_W = 12
) (
   input  logic signed [ACC_W-1:0]  a,
   input  logic signed [PROD_W-1:0] b,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     ovf
);

   logic signed [ACC_W-1:0] b_ext;
   logic signed [ACC_W-1:0] sum_raw;

   // Size cast of a signed operand sign-extends.
   assign b_ext   = ACC_W'(b);
   assign sum_raw = a + b_ext;

   // Same-sign operands producing a different-sign result is the only overflow case.
   assign ovf = (a[ACC_W-1] == b_ext[ACC_W-1]) && (sum_raw[ACC_W-1] != a[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

   // On overflow both operands share a's sign, which gives the clamp direction.
   assign sum = ovf ? (a[ACC_W-1] ? MIN_V : MAX_V) : sum_raw;
`else
   assign sum = sum_raw;
`endif

endmodule

// File: rtl/booth_accum.sv
// rtl/booth_accum.sv - frame accumulator behind the Booth multiplier: sums N_TERMS products per frame
// Ports: clk, rst (async, active-high), clr (sync frame abort)
//        in_valid/in_ready/product  - product stream from the multiplier
//        out_valid/out_ready        - frame result handshake
//        out_sum (ACC_W signed), out_ovf (sticky per-frame overflow)
// Build option: BOOTH_ACC_SAT_EN makes the accumulator saturate instead of wrap.
module booth_accum
   import booth_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [PROD_W-1:0] product,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_sum,
   output logic                     out_ovf
);

   localparam int CNT_W = $clog2(N_TERMS + 1);

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] add_sum;
   logic                    add_ovf;
   logic                    last_term;

   booth_acc_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .a   (acc),
      .b   (product),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   // in_ready is forced low during reset so no product is taken while state is clearing.
   assign in_ready  = (state == ACC) && !rst;
   assign out_valid = (state == DONE);
   assign last_term = (cnt == CNT_W'(N_TERMS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ACC;
         acc     <= '0;
         cnt     <= '0;
         out_sum <= '0;
         out_ovf <= 1'b0;
      end else if (clr) begin
         // Abort wins over accept and over the output handshake; out_sum is kept.
         state   <= ACC;
         acc     <= '0;
         cnt     <= '0;
         out_ovf <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  acc     <= add_sum;
                  cnt     <= cnt + CNT_W'(1);
                  out_ovf <= out_ovf | add_ovf;
                  if (last_term) begin
                     state   <= DONE;
                     out_sum <= add_sum;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state   <= ACC;
                  acc     <= '0;
                  cnt     <= '0;
                  out_ovf <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_accum.sv
// tb/tb_booth_accum.sv - scoreboard bench for booth_accum (default and 8-bit accumulator instances)
module tb_booth_accum;

   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic              in_valid;
   logic              out_ready;
   logic signed [7:0] product;

   logic               in_ready, out_valid, out_ovf;
   logic signed [11:0] out_sum;
   logic               in_ready8, out_valid8, out_ovf8;
   logic signed [7:0]  out_sum8;

   typedef struct {
      int s12;
      bit o12;
      int s8;
      bit o8;
   } exp_t;

   exp_t exp_q[$];
   int   frame[$];
   bit   pending;
   bit   sat_build;
   int   ncmp;
   int   nerr;

   always #5 clk = ~clk;

   booth_accum #(.N_TERMS(N), .ACC_W(12)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .product(product), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf)
   );

   booth_accum #(.N_TERMS(N), .ACC_W(8)) dut8 (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready8),
      .product(product), .out_valid(out_valid8), .out_ready(out_ready),
      .out_sum(out_sum8), .out_ovf(out_ovf8)
   );

   task automatic check(input string name, input int act, input int req);
      ncmp++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: sum a frame of products in plain integers, flag any step outside the range.
   function automatic void model(input int w, input bit sat, output int s, output bit o);
      int lo;
      int hi;
      int a;
      lo = -(1 << (w - 1));
      hi = (1 << (w - 1)) - 1;
      a  = 0;
      o  = 1'b0;
      foreach (frame[i]) begin
         int t;
         t = a + frame[i];
         if (t > hi) begin
            o = 1'b1;
            t = sat ? hi : t - (1 << w);
         end else if (t < lo) begin
            o = 1'b1;
            t = sat ? lo : t + (1 << w);
         end
         a = t;
      end
      s = a;
   endfunction

   // Drive one cycle of inputs, then update the model for the edge that consumed them.
   task automatic step(input bit v, input int p, input bit rdy, input bit c, input bit r);
      exp_t e;
      in_valid  = v;
      product   = 8'(p);
      out_ready = rdy;
      clr       = c;
      rst       = r;
      @(posedge clk);
      #1;
      if (r || c) begin
         if (pending) void'(exp_q.pop_back());
         pending = 1'b0;
         frame.delete();
      end else if (pending) begin
         if (rdy) pending = 1'b0;
      end else if (v) begin
         frame.push_back(p);
         if (frame.size() == N) begin
            model(12, sat_build, e.s12, e.o12);
            model(8, sat_build, e.s8, e.o8);
            exp_q.push_back(e);
            pending = 1'b1;
            frame.delete();
         end
      end
   endtask

   // Monitor: checks handshake flags every cycle and the held result against the scoreboard.
   always @(negedge clk) begin
      check("in_ready", int'(in_ready), int'(!rst && !pending));
      check("in_ready8", int'(in_ready8), int'(!rst && !pending));
      check("out_valid", int'(out_valid), int'(!rst && pending));
      check("out_valid8", int'(out_valid8), int'(!rst && pending));
      if (!rst && pending) begin
         if (exp_q.size() == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL scoreboard_empty: result held with nothing expected at %0t", $time);
         end else begin
            check("out_sum", int'(out_sum), exp_q[0].s12);
            check("out_ovf", int'(out_ovf), int'(exp_q[0].o12));
            check("out_sum8", int'(out_sum8), exp_q[0].s8);
            check("out_ovf8", int'(out_ovf8), int'(exp_q[0].o8));
            if (out_ready && !clr) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      ncmp      = 0;
      nerr      = 0;
      pending   = 1'b0;
`ifdef BOOTH_ACC_SAT_EN
      sat_build = 1'b1;
`else
      sat_build = 1'b0;
`endif
      rst       = 1'b1;
      clr       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      product   = '0;
      #3;
      check("reset_sum", int'(out_sum), 0);
      check("reset_ovf", int'(out_ovf), 0);
      check("reset_sum8", int'(out_sum8), 0);
      step(1, 5, 1, 0, 1);
      step(0, 0, 1, 0, 0);

      // Basic frame
      step(1, 10, 1, 0, 0);
      step(1, -20, 1, 0, 0);
      step(1, 30, 1, 0, 0);
      step(1, 40, 1, 0, 0);
      check("basic_valid", int'(out_valid), 1);
      check("basic_sum", int'(out_sum), 60);
      check("basic_ovf", int'(out_ovf), 0);
      step(1, 9, 1, 0, 0);

      // Overflow on the 8-bit instance
      step(1, 64, 1, 0, 0);
      step(1, 64, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      check("sat_sum8", int'(out_sum8), sat_build ? 127 : -128);
      check("sat_ovf8", int'(out_ovf8), 1);
      check("sat_sum12", int'(out_sum), 128);
      step(0, 0, 1, 0, 0);

      // Backpressure: result held, products refused
      for (int i = 0; i < N; i++) step(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 50, 0, 0, 0);
      check("bp_sum", int'(out_sum), 4);
      step(1, 50, 1, 0, 0);
      step(1, 7, 1, 0, 0);
      check("bp_next_started", int'(frame.size()), 1);
      step(1, 7, 1, 0, 0);
      step(1, 7, 1, 0, 0);
      step(1, 7, 1, 0, 0);
      check("bp_next_sum", int'(out_sum), 28);
      step(0, 0, 1, 0, 0);

      // Gaps in in_valid
      step(1, 5, 1, 0, 0);
      step(0, -3, 1, 0, 0);
      step(1, 7, 1, 0, 0);
      step(0, -1, 1, 0, 0);
      step(1, -2, 1, 0, 0);
      step(0, 9, 1, 0, 0);
      step(1, -2, 1, 0, 0);
      check("gap_sum", int'(out_sum), 8);
      step(0, 0, 1, 0, 0);

      // clr mid-frame together with a valid product
      step(1, 20, 1, 0, 0);
      step(1, 20, 1, 0, 0);
      step(1, 50, 1, 1, 0);
      step(1, 1, 1, 0, 0);
      step(1, 2, 1, 0, 0);
      step(1, 3, 1, 0, 0);
      step(1, 4, 1, 0, 0);
      check("clr_sum", int'(out_sum), 10);
      step(0, 0, 1, 0, 0);

      // rst mid-frame
      step(1, 30, 1, 0, 0);
      step(1, 30, 1, 0, 0);
      step(1, 30, 1, 0, 0);
      step(1, 30, 1, 0, 1);
      step(1, -56, 1, 0, 0);
      step(1, -56, 1, 0, 0);
      step(1, -56, 1, 0, 0);
      step(1, -56, 1, 0, 0);
      check("rst_sum", int'(out_sum), -224);
      check("rst_ovf", int'(out_ovf), 0);
      check("rst_ovf8", int'(out_ovf8), 1);
      step(0, 0, 1, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0,
              int'($urandom_range(0, 120)) - 56,
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0,
              $urandom_range(0, 150) == 0);
      end

      // Drain
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      check("drain_pending", int'(pending), 0);
      check("drain_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
